// File: rtl/mips32_multicycle_ctrl.sv
// Multi-cycle MIPS32 control FSM: sequences fetch/decode/exec/mem/wb over one shared memory
// port, drives datapath enables and mux selects, and keeps cycle/retired-instruction counters.
module mips32_multicycle_ctrl #(
  parameter logic [5:0]  HALT_OP = 6'b111111,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             cond_true,
  input  logic             ovf,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic             mdr_we,
  output logic             aluout_we,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_b_sel,
  output logic [1:0]       alu_mode,
  output logic             extend_sel,
  output logic             rd_sel,
  output logic             wb_src,
  output logic [3:0]       reg_byte_we,
  output logic             trap,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycle_q, instret_q;
  logic             retire;

  // Instruction class decode; opcode/funct come from the IR so they are stable after FETCH.
  logic is_r, is_ialu, is_lw, is_sw, is_br, is_j, is_halt, is_legal, ovf_op;

  always_comb begin
    is_r     = (opcode == 6'b000000);
    is_ialu  = (opcode[5:3] == 3'b001);
    is_lw    = (opcode == 6'b100011);
    is_sw    = (opcode == 6'b101011);
    is_br    = (opcode == 6'b000100) || (opcode == 6'b000101);
    is_j     = (opcode == 6'b000010);
    is_halt  = (opcode == HALT_OP);
    is_legal = is_r || is_ialu || is_lw || is_sw || is_br || is_j;
    ovf_op   = (is_r && (funct == 6'b100000 || funct == 6'b100010)) || (opcode == 6'b001000);
  end

  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    mdr_we       = 1'b0;
    aluout_we    = 1'b0;
    pc_src       = 2'd0;
    alu_b_sel    = 2'd0;
    alu_mode     = 2'd0;
    extend_sel   = 1'b0;
    rd_sel       = 1'b0;
    wb_src       = 1'b0;
    reg_byte_we  = 4'b0000;
    trap         = 1'b0;
    illegal      = 1'b0;
    halted       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        // HALT_OP is checked first so it wins even if parameterised into a legal class.
        if (is_halt) begin
          state_d = StHalt;
        end else if (is_j) begin
          pc_src  = 2'd2;
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = StFetch;
        end else if (is_legal) begin
          state_d = StExec;
        end else begin
          illegal = 1'b1;
          state_d = StFetch;
        end
      end
      StExec: begin
        if (is_r) begin
          alu_mode  = 2'd1;
          aluout_we = 1'b1;
          state_d   = StWb;
        end else if (is_ialu) begin
          alu_mode   = 2'd2;
          alu_b_sel  = (opcode == 6'b001111) ? 2'd2 : 2'd1;
          extend_sel = (opcode[2] == 1'b0);
          aluout_we  = 1'b1;
          state_d    = StWb;
        end else if (is_lw || is_sw) begin
          alu_b_sel  = 2'd1;
          extend_sel = 1'b1;
          aluout_we  = 1'b1;
          state_d    = StMem;
        end else begin
          // Branch: ALU compares, PC takes the target only when the condition holds.
          alu_mode   = 2'd3;
          extend_sel = 1'b1;
          pc_src     = 2'd1;
          pc_we      = cond_true;
          retire     = 1'b1;
          state_d    = StFetch;
        end
      end
      StMem: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_sw;
        if (mem_ack) begin
          if (is_sw) begin
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            mdr_we  = 1'b1;
            state_d = StWb;
          end
        end
      end
      StWb: begin
        rd_sel = is_r;
        wb_src = is_lw;
        if (ovf_op && ovf) begin
          trap = 1'b1;
        end else begin
          reg_byte_we = 4'b1111;
          retire      = 1'b1;
        end
        state_d = StFetch;
      end
      StHalt: begin
        halted = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != StIdle && state_q != StHalt) cycle_q <= cycle_q + 1'b1;
      if (retire) instret_q <= instret_q + 1'b1;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: tb/tb_mips32_multicycle_ctrl.sv
// Scoreboard bench for mips32_multicycle_ctrl: each instruction's expected profile is queued
// when it is driven, then popped and compared once the DUT starts the next fetch or halts.
module tb_mips32_multicycle_ctrl;
  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset, run, cond_true, ovf, mem_ack;
  logic [5:0]       opcode, funct;
  logic             mem_req, mem_we, mem_addr_sel, ir_we, pc_we, mdr_we, aluout_we;
  logic [1:0]       pc_src, alu_b_sel, alu_mode;
  logic             extend_sel, rd_sel, wb_src, trap, illegal, halted;
  logic [3:0]       reg_byte_we;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  mips32_multicycle_ctrl #(.HALT_OP(6'b111111), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct(funct),
    .cond_true(cond_true), .ovf(ovf), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we), .mdr_we(mdr_we),
    .aluout_we(aluout_we), .pc_src(pc_src), .alu_b_sel(alu_b_sel), .alu_mode(alu_mode),
    .extend_sel(extend_sel), .rd_sel(rd_sel), .wb_src(wb_src), .reg_byte_we(reg_byte_we),
    .trap(trap), .illegal(illegal), .halted(halted), .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] cycles;
    logic [7:0] retire;
    logic [3:0] trap;
    logic [3:0] illegal;
    logic [3:0] mdr;
    logic [7:0] memreq;
    logic [7:0] memwe;
    logic [3:0] pcwe;
    logic [1:0] pcsrc;
    logic [3:0] rbwe;
    logic       wbsrc;
    logic       rdsel;
    logic [4:0] ex;     // {alu_mode, alu_b_sel, extend_sel} while the ALU result is used
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cyc_total = 0;
  int   exp_ret_total = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Entered at a negedge with the DUT in FETCH; returns at the negedge where the next
  // fetch begins (or HALT is reached), without consuming that cycle.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic cnd, input logic ov, input int fw, input int mw,
                           input int cyc, input int ret, input int trp, input int ill,
                           input int mdr, input int mrq, input int mwe, input int pcw,
                           input int pcs, input int rbw, input int wbs, input int rds,
                           input int ex);
    exp_t e, o;
    int   fc = 0, mc = 0, unstable = 0;
    logic fetched = 1'b0, done = 1'b0;
    logic prev_req = 1'b0, prev_ack = 1'b0, prev_sel = 1'b0, prev_we = 1'b0;
    logic [CNT_W-1:0] c0, i0;
    e = '{cycles: 8'(cyc), retire: 8'(ret), trap: 4'(trp), illegal: 4'(ill), mdr: 4'(mdr),
          memreq: 8'(mrq), memwe: 8'(mwe), pcwe: 4'(pcw), pcsrc: 2'(pcs), rbwe: 4'(rbw),
          wbsrc: wbs[0], rdsel: rds[0], ex: 5'(ex)};
    exp_q.push_back(e);
    exp_cyc_total += cyc;
    exp_ret_total += ret;
    o = '0;
    opcode = op; funct = fn; cond_true = cnd; ovf = ov;
    c0 = cycle_cnt; i0 = instret_cnt;
    for (int k = 0; k < 64; k++) begin
      if (halted || (fetched && mem_req && !mem_addr_sel)) begin
        done = 1'b1;
        break;
      end
      if (mem_req && !mem_addr_sel) begin
        mem_ack = (fc == fw); fc++;
      end else if (mem_req) begin
        mem_ack = (mc == mw); mc++;
      end else begin
        mem_ack = 1'b0;
      end
      #1;
      if (mem_req && prev_req && !prev_ack && (mem_addr_sel !== prev_sel || mem_we !== prev_we))
        unstable++;
      prev_req = mem_req; prev_ack = mem_ack; prev_sel = mem_addr_sel; prev_we = mem_we;
      if (ir_we) fetched = 1'b1;
      o.cycles  += 1;
      o.trap    += 4'(trap);
      o.illegal += 4'(illegal);
      o.mdr     += 4'(mdr_we);
      o.memreq  += 8'(mem_req);
      o.memwe   += 8'(mem_we);
      o.pcwe    += 4'(pc_we);
      o.rbwe    |= reg_byte_we;
      o.wbsrc   |= wb_src;
      o.rdsel   |= rd_sel;
      if (pc_we && !ir_we) o.pcsrc = pc_src;
      if (aluout_we || alu_mode == 2'd3) o.ex = {alu_mode, alu_b_sel, extend_sel};
      @(negedge clk);
    end
    o.retire = 8'(instret_cnt - i0);
    check_eq({name, ".done"}, 32'(done), 32'd1);
    if (exp_q.size() == 0) begin
      check_eq({name, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq({name, ".cycles"}, 32'(o.cycles), 32'(e.cycles));
      check_eq({name, ".cycle_cnt"}, 32'(cycle_cnt - c0), 32'(e.cycles));
      check_eq({name, ".retire"}, 32'(o.retire), 32'(e.retire));
      check_eq({name, ".trap"}, 32'(o.trap), 32'(e.trap));
      check_eq({name, ".illegal"}, 32'(o.illegal), 32'(e.illegal));
      check_eq({name, ".mdr_we"}, 32'(o.mdr), 32'(e.mdr));
      check_eq({name, ".mem_req"}, 32'(o.memreq), 32'(e.memreq));
      check_eq({name, ".mem_we"}, 32'(o.memwe), 32'(e.memwe));
      check_eq({name, ".pc_we"}, 32'(o.pcwe), 32'(e.pcwe));
      check_eq({name, ".pc_src"}, 32'(o.pcsrc), 32'(e.pcsrc));
      check_eq({name, ".reg_byte_we"}, 32'(o.rbwe), 32'(e.rbwe));
      check_eq({name, ".wb_src"}, 32'(o.wbsrc), 32'(e.wbsrc));
      check_eq({name, ".rd_sel"}, 32'(o.rdsel), 32'(e.rdsel));
      check_eq({name, ".alu_ctl"}, 32'(o.ex), 32'(e.ex));
      check_eq({name, ".stable"}, 32'(unstable), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; opcode = '0; funct = '0;
    cond_true = 1'b0; ovf = 1'b0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset.mem_req", 32'(mem_req), 32'd0);
    check_eq("reset.outputs", 32'({ir_we, pc_we, mdr_we, aluout_we, pc_src, alu_b_sel, alu_mode,
             extend_sel, rd_sel, wb_src, reg_byte_we, trap, illegal, halted, mem_we}), 32'd0);
    check_eq("reset.cycle_cnt", cycle_cnt, 32'd0);
    check_eq("reset.instret_cnt", instret_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b0; run = 1'b1;
    @(negedge clk);

    //        name     op      fn      cnd  ov  fw mw cyc ret trp ill mdr mrq mwe pcw pcs rbw wbs rds ex
    run_instr("add",   6'h00, 6'h20, 0, 0, 0, 0, 4,  1, 0, 0, 0, 1, 0, 1, 0, 15, 0, 1, 'h08);
    check_eq("add.instret_abs", instret_cnt, 32'd1);
    check_eq("add.cycle_abs", cycle_cnt, 32'd4);
    run_instr("lw",    6'h23, 6'h00, 0, 0, 3, 3, 11, 1, 0, 0, 1, 8, 0, 1, 0, 15, 1, 0, 'h03);
    run_instr("beq",   6'h04, 6'h00, 1, 0, 0, 0, 3,  1, 0, 0, 0, 1, 0, 2, 1, 0,  0, 0, 'h19);
    run_instr("bne",   6'h05, 6'h00, 0, 0, 0, 0, 3,  1, 0, 0, 0, 1, 0, 1, 0, 0,  0, 0, 'h19);
    run_instr("addi",  6'h08, 6'h00, 0, 1, 0, 0, 4,  0, 1, 0, 0, 1, 0, 1, 0, 0,  0, 0, 'h13);
    run_instr("sub",   6'h00, 6'h22, 0, 1, 0, 0, 4,  0, 1, 0, 0, 1, 0, 1, 0, 0,  0, 1, 'h08);
    run_instr("and",   6'h00, 6'h24, 0, 1, 0, 0, 4,  1, 0, 0, 0, 1, 0, 1, 0, 15, 0, 1, 'h08);
    run_instr("ori",   6'h0D, 6'h00, 0, 1, 0, 0, 4,  1, 0, 0, 0, 1, 0, 1, 0, 15, 0, 0, 'h12);
    run_instr("lui",   6'h0F, 6'h00, 0, 0, 0, 0, 4,  1, 0, 0, 0, 1, 0, 1, 0, 15, 0, 0, 'h14);
    run_instr("sw",    6'h2B, 6'h00, 0, 0, 1, 2, 7,  1, 0, 0, 0, 5, 3, 1, 0, 0,  0, 0, 'h03);
    run_instr("j",     6'h02, 6'h00, 0, 0, 0, 0, 2,  1, 0, 0, 0, 1, 0, 2, 2, 0,  0, 0, 'h00);
    run_instr("illeg", 6'h11, 6'h00, 0, 0, 0, 0, 2,  0, 0, 1, 0, 1, 0, 1, 0, 0,  0, 0, 'h00);
    run_instr("halt",  6'h3F, 6'h00, 0, 0, 0, 0, 2,  0, 0, 0, 0, 1, 0, 1, 0, 0,  0, 0, 'h00);

    mem_ack = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check_eq("halt.halted", 32'(halted), 32'd1);
    check_eq("halt.mem_req", 32'(mem_req), 32'd0);
    check_eq("halt.cycle_cnt", cycle_cnt, 32'(exp_cyc_total));
    check_eq("halt.instret_cnt", instret_cnt, 32'(exp_ret_total));

    // Restart, then hit the sw with reset while it waits in MEM.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; opcode = 6'h2B; funct = '0;
    @(negedge clk);
    begin
      int mc = 0;
      for (int k = 0; k < 20 && mc < 3; k++) begin
        mem_ack = mem_req && !mem_addr_sel;
        if (mem_req && mem_addr_sel) mc++;
        if (mc < 3) @(negedge clk);
      end
      check_eq("rst.reached_mem", 32'(mc), 32'd3);
    end
    mem_ack = 1'b0;
    #1;
    check_eq("rst.pre_mem_req", 32'(mem_req), 32'd1);
    check_eq("rst.pre_mem_we", 32'(mem_we), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check_eq("rst.mem_req", 32'(mem_req), 32'd0);
    check_eq("rst.mem_we", 32'(mem_we), 32'd0);
    check_eq("rst.cycle_cnt", cycle_cnt, 32'd0);
    check_eq("rst.instret_cnt", instret_cnt, 32'd0);
    @(negedge clk);
    run = 1'b0; reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("idle.mem_req", 32'(mem_req), 32'd0);
    check_eq("idle.cycle_cnt", cycle_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mips32_multicycle_ctrl.md
Name: mips32_multicycle_ctrl

Overview:
Control FSM for the multi-cycle MIPS32 datapath that shares one unified memory port between instruction fetch and load/store. Each instruction passes through FETCH, DECODE, EXEC, MEM and WB states. In each state the block drives the datapath register write-enables and mux selects. It also runs a req/ack handshake with memory and keeps cycle and retired-instruction counters.

Parameters:
HALT_OP, 6'b111111, opcode that parks the FSM in HALT
CNT_W, 32, width of cycle_cnt and instret_cnt

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  reset, asynchronous, active-high
run  in  1  leave IDLE and start fetching
opcode  in  6  IR[31:26] from the datapath IR register
funct  in  6  IR[5:0]
cond_true  in  1  branch condition from the condition selector (beq/bne)
ovf  in  1  registered ALU overflow, valid in WB
mem_ack  in  1  memory completed the current request
mem_req  out  1  memory request
mem_we  out  1  1 = store
mem_addr_sel  out  1  0 = PC, 1 = ALUOut
ir_we, pc_we, mdr_we, aluout_we  out  1 each  datapath register enables
pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target
alu_b_sel  out  2  0 = Rt, 1 = ext imm, 2 = imm<<16
alu_mode  out  2  0 = add, 1 = by funct, 2 = by opcode, 3 = sub/compare
extend_sel  out  1  1 = sign-extend imm16
rd_sel  out  1  1 = Rd, 0 = Rt
wb_src  out  1  0 = ALUOut, 1 = MDR
reg_byte_we  out  4  register-file byte write enable
trap, illegal  out  1 each  single-cycle pulses
halted  out  1  FSM is in HALT
cycle_cnt, instret_cnt  out  CNT_W each  performance counters

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Outputs are Moore by state, with Mealy qualification by mem_ack and decoded class.
- Reset (any time, asynchronous): state = IDLE; counters = 0; every output = 0.
- IDLE: all outputs 0. Go to FETCH when run = 1.
- FETCH:
  - mem_req = 1, mem_addr_sel = 0, mem_we = 0.
  - On mem_ack: ir_we = 1, pc_we = 1, pc_src = 0; go to DECODE.
  - ack in the same cycle req rises is legal, giving a 1-cycle fetch.
- DECODE classes:
  - R: opcode 0.
  - I-ALU: 001000 to 001111.
  - LW: 100011. SW: 101011. BR: 000100/000101. J: 000010.
  - HALT_OP: go to HALT.
  - Any other opcode: illegal pulse, then go to FETCH.
- DECODE transitions:
  - J: pc_src = 2, pc_we = 1, retire, go to FETCH.
  - All other legal classes: go to EXEC.
- EXEC:
  - R: alu_b_sel = 0, alu_mode = 1, aluout_we = 1; go to WB.
  - I-ALU: alu_mode = 2, aluout_we = 1, go to WB. alu_b_sel = 2 for LUI (001111), else 1. extend_sel = 1 for 001000, 001001, 001010, 001011, else 0.
  - LW/SW: alu_mode = 0, alu_b_sel = 1, extend_sel = 1, aluout_we = 1; go to MEM.
  - BR: alu_mode = 3, alu_b_sel = 0, extend_sel = 1, pc_src = 1, pc_we = cond_true; retire; go to FETCH.
- MEM:
  - mem_req = 1, mem_addr_sel = 1, mem_we = (SW). Held stable until ack.
  - On ack: SW retires and goes to FETCH; LW asserts mdr_we = 1 and goes to WB.
- WB:
  - rd_sel = (R); wb_src = (LW); reg_byte_we = 4'b1111.
  - Overflow exception: if the instruction is add (R, funct 100000), sub (100010) or addi (001000) and ovf = 1, then reg_byte_we = 0, trap = 1 and the instruction does not retire.
  - Otherwise retire. Go to FETCH.
- mem_ack is ignored whenever mem_req = 0. mem_addr_sel and mem_we do not change while mem_req = 1 and ack is not yet seen.
- HALT: halted = 1, all other outputs 0. Leave only by reset.
- Counters:
  - cycle_cnt += 1 every cycle the state is not IDLE or HALT.
  - instret_cnt += 1 in each retire cycle.
  - Both wrap modulo 2^CNT_W with no saturation.
- Cycles per instruction with zero-wait memory: J 2, BR 3, R/I-ALU 4, SW 4, LW 5. Each memory wait cycle adds 1.

Test Plan:
- reset, run = 1, zero-wait memory, R-type add with ovf = 0 -> states F,D,E,W; reg_byte_we = 4'hF in cycle 4; instret_cnt = 1, cycle_cnt = 4.
- lw with mem_ack delayed 3 cycles in both FETCH and MEM -> mem_req held 4 cycles each with stable mem_addr_sel; mdr_we pulses once; wb_src = 1; 11 cycles total.
- beq with cond_true = 1, then bne with cond_true = 0 -> pc_we = 1/pc_src = 1 in the first EXEC, pc_we = 0 in the second; instret_cnt = 2.
- addi with ovf = 1 in WB -> trap pulses 1 cycle, reg_byte_we = 0, instret_cnt unchanged, next state FETCH.
- opcode 6'b010001 -> illegal pulse in DECODE, then FETCH. Opcode HALT_OP -> halted = 1 and counters frozen for 20 cycles.
- reset asserted mid-MEM of sw with mem_req = 1 -> mem_req and mem_we drop immediately with no clock edge; counters = 0; state IDLE.
